// File: rtl/reg_file_sb_if.sv
// Bus bundle between the register file and its decode/writeback clients.
// The master side drives reads, writeback, busy-set and clear requests.
interface reg_file_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 3
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_dout;
  logic [NRD-1:0]        rd_busy;
  logic                  w_en;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_din;
  logic                  set_en;
  logic [ADDR_W-1:0]     set_addr;
  logic                  clr_req;
  logic                  clr_busy;

  modport master (
    output rd_addr, w_en, w_addr, w_din, set_en, set_addr, clr_req,
    input  rd_dout, rd_busy, clr_busy
  );

  modport slave (
    input  rd_addr, w_en, w_addr, w_din, set_en, set_addr, clr_req,
    output rd_dout, rd_busy, clr_busy
  );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write bypass, busy scoreboard and a
// sequential sweep-clear engine. Entry 0 is hardwired to zero and never busy.
module reg_file_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 3,
  parameter int unsigned BYPASS = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  reg_file_sb_if.slave  bus
);
  localparam int unsigned Depth = 1 << ADDR_W;
  localparam bit BypassEn = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] LastPtr = '1;
  localparam logic [ADDR_W-1:0] FirstPtr = ADDR_W'(1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];
  logic [Depth-1:0]  busy_q, busy_d;

  logic [NRD*DATA_W-1:0] rd_dout;
  logic [NRD-1:0]        rd_busy;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (bus.w_en && (bus.w_addr != '0)) begin
          mem_d[bus.w_addr]  = bus.w_din;
          busy_d[bus.w_addr] = 1'b0;
        end
        // Applied after the clear so a new producer on the same register wins.
        if (bus.set_en && (bus.set_addr != '0)) begin
          busy_d[bus.set_addr] = 1'b1;
        end
        if (bus.clr_req) begin
          state_d = StSweep;
          ptr_d   = FirstPtr;
        end
      end
      StSweep: begin
        mem_d[ptr_q]  = '0;
        busy_d[ptr_q] = 1'b0;
        if (ptr_q == LastPtr) begin
          state_d = StIdle;
          ptr_d   = FirstPtr;
        end else begin
          ptr_d = ptr_q + FirstPtr;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = FirstPtr;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= FirstPtr;
      mem_q   <= '{default: '0};
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic              byp;
    rd_dout = '0;
    rd_busy = '0;
    addr    = '0;
    byp     = 1'b0;
    for (int i = 0; i < int'(NRD); i++) begin
      addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
      byp  = BypassEn && (state_q == StIdle) && bus.w_en && (bus.w_addr == addr);
      if (addr != '0) begin
        rd_dout[i*DATA_W +: DATA_W] = byp ? bus.w_din : mem_q[addr];
        rd_busy[i]                  = !byp && busy_q[addr];
      end
    end
  end

  assign bus.rd_dout  = rd_dout;
  assign bus.rd_busy  = rd_busy;
  assign bus.clr_busy = (state_q == StSweep);
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing instance under test plus a
// non-bypassing twin fed the same stimulus for the forwarding comparison.
module tb_reg_file_sb;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();
  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus0 ();

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(0)) u_dut_nobyp (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus0)
  );

  assign bus0.rd_addr  = bus.rd_addr;
  assign bus0.w_en     = bus.w_en;
  assign bus0.w_addr   = bus.w_addr;
  assign bus0.w_din    = bus.w_din;
  assign bus0.set_en   = bus.set_en;
  assign bus0.set_addr = bus.set_addr;
  assign bus0.clr_req  = bus.clr_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    bus.rd_addr = {a2, a1, a0};
    #1;
  endtask

  function automatic logic [31:0] dout(input int p);
    return bus.rd_dout[p*DW +: DW];
  endfunction

  function automatic logic [31:0] dout0(input int p);
    return bus0.rd_dout[p*DW +: DW];
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.w_en   = 1'b1;
    bus.w_addr = a;
    bus.w_din  = d;
    tick();
    bus.w_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    bus.rd_addr  = '0;
    bus.w_en     = 1'b0;
    bus.w_addr   = '0;
    bus.w_din    = '0;
    bus.set_en   = 1'b0;
    bus.set_addr = '0;
    bus.clr_req  = 1'b0;
    rst_n        = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset clears data and busy
    wr(5'd5, 32'hDEADBEEF);
    bus.set_en = 1'b1; bus.set_addr = 5'd3;
    tick();
    bus.set_en = 1'b0;
    set_rd(5'd5, 5'd3, 5'd10);
    check_eq("pre_rst_r5", dout(0), 32'hDEADBEEF);
    check_eq("pre_rst_busy", 32'(bus.rd_busy), 32'h2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rst_r5", dout(0), 32'h0);
    check_eq("rst_busy", 32'(bus.rd_busy), 32'h0);
    check_eq("rst_clr_busy", 32'(bus.clr_busy), 32'h0);

    // Entry 0 hardwired
    bus.set_en = 1'b1; bus.set_addr = 5'd0;
    wr(5'd0, 32'hFFFF_FFFF);
    bus.set_en = 1'b0;
    set_rd(5'd0, 5'd0, 5'd0);
    check_eq("r0_data", dout(0), 32'h0);
    check_eq("r0_busy", 32'(bus.rd_busy), 32'h0);
    bus.w_en = 1'b1; bus.w_addr = 5'd0; bus.w_din = 32'hAAAA_AAAA;
    #1;
    check_eq("r0_nobypass", dout(1), 32'h0);
    bus.w_en = 1'b0;

    // Bypass vs no bypass
    wr(5'd7, 32'h1111_1111);
    wr(5'd8, 32'h2222_2222);
    bus.w_en = 1'b1; bus.w_addr = 5'd7; bus.w_din = 32'h1234_5678;
    set_rd(5'd7, 5'd8, 5'd0);
    check_eq("byp_port0", dout(0), 32'h1234_5678);
    check_eq("byp_port1", dout(1), 32'h2222_2222);
    check_eq("nobyp_old", dout0(0), 32'h1111_1111);
    tick();
    bus.w_en = 1'b0;
    #1;
    check_eq("nobyp_new", dout0(0), 32'h1234_5678);
    check_eq("byp_after", dout(0), 32'h1234_5678);

    // Scoreboard
    set_rd(5'd3, 5'd0, 5'd0);
    bus.set_en = 1'b1; bus.set_addr = 5'd3;
    #1;
    check_eq("set_same_cycle", 32'(bus.rd_busy[0]), 32'h0);
    tick();
    bus.set_en = 1'b0;
    check_eq("set_next_cycle", 32'(bus.rd_busy[0]), 32'h1);
    bus.w_en = 1'b1; bus.w_addr = 5'd3; bus.w_din = 32'h33;
    #1;
    check_eq("wb_same_busy", 32'(bus.rd_busy[0]), 32'h0);
    check_eq("wb_same_data", dout(0), 32'h33);
    tick();
    bus.w_en = 1'b0;
    #1;
    check_eq("wb_after_busy", 32'(bus.rd_busy[0]), 32'h0);
    bus.set_en = 1'b1; bus.set_addr = 5'd3;
    wr(5'd3, 32'h44);
    bus.set_en = 1'b0;
    #1;
    check_eq("set_wb_busy", 32'(bus.rd_busy[0]), 32'h1);
    check_eq("set_wb_data", dout(0), 32'h44);

    // Multi-port
    wr(5'd1, 32'hA1A1_0001);
    wr(5'd2, 32'hB2B2_0002);
    wr(5'd31, 32'hC3C3_001F);
    set_rd(5'd1, 5'd2, 5'd31);
    check_eq("mp_p0", dout(0), 32'hA1A1_0001);
    check_eq("mp_p1", dout(1), 32'hB2B2_0002);
    check_eq("mp_p2", dout(2), 32'hC3C3_001F);
    set_rd(5'd31, 5'd31, 5'd31);
    check_eq("same_p0", dout(0), 32'hC3C3_001F);
    check_eq("same_p1", dout(1), 32'hC3C3_001F);
    check_eq("same_p2", dout(2), 32'hC3C3_001F);

    // Sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
    bus.set_en = 1'b1; bus.set_addr = 5'd10;
    tick();
    bus.set_en = 1'b0;
    set_rd(5'd10, 5'd2, 5'd20);
    check_eq("pre_sweep_busy", 32'(bus.rd_busy), 32'h1);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    cnt = 0;
    while (bus.clr_busy && cnt < 100) begin
      cnt++;
      if (cnt == 10) begin
        bus.w_en = 1'b1; bus.w_addr = 5'd4; bus.w_din = 32'h999;
        bus.set_en = 1'b1; bus.set_addr = 5'd4; bus.clr_req = 1'b1;
        #1;
        check_eq("mid_sweep_r2", dout(1), 32'h0);
        check_eq("mid_sweep_r20", dout(2), 32'h114);
      end
      tick();
      bus.w_en = 1'b0; bus.set_en = 1'b0; bus.clr_req = 1'b0;
    end
    check_eq("sweep_cycles", 32'(cnt), 32'd31);
    set_rd(5'd4, 5'd10, 5'd0);
    check_eq("lost_write_r4", dout(0), 32'h0);
    check_eq("post_sweep_busy", 32'(bus.rd_busy), 32'h0);
    check_eq("post_sweep_clr_busy", 32'(bus.clr_busy), 32'h0);
    cnt = 0;
    for (int i = 1; i < 32; i++) begin
      set_rd(5'(i), 5'd0, 5'd0);
      if (dout(0) != 32'h0 || bus.rd_busy[0]) cnt++;
    end
    check_eq("post_sweep_nonzero", 32'(cnt), 32'd0);

    // Reset mid-sweep
    wr(5'd5, 32'h55);
    wr(5'd30, 32'h3030);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_rd(5'd5, 5'd30, 5'd0);
    check_eq("rst_mid_clr_busy", 32'(bus.clr_busy), 32'h0);
    check_eq("rst_mid_r5", dout(0), 32'h0);
    check_eq("rst_mid_r30", dout(1), 32'h0);
    wr(5'd1, 32'h77);
    wr(5'd2, 32'h88);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    set_rd(5'd1, 5'd2, 5'd0);
    check_eq("restart_first_r1", dout(0), 32'h77);
    check_eq("restart_clr_busy", 32'(bus.clr_busy), 32'h1);
    tick();
    check_eq("restart_ptr1_r1", dout(0), 32'h0);
    check_eq("restart_ptr1_r2", dout(1), 32'h88);
    cnt = 1;
    while (bus.clr_busy && cnt < 100) begin
      cnt++;
      tick();
    end
    check_eq("restart_cycles", 32'(cnt), 32'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-read-port register file for the pipelined CPU datapath.
- Generalises data width, depth and read-port count.
- Adds write-to-read bypass, a per-register busy scoreboard for hazard detection, and a sequential sweep-clear engine that zeroes the file without a reset.
- Sits between the decode stage (reads, busy set) and the writeback stage (writes, busy clear).

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NRD, 3, number of independent read ports
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
rd_addr  in  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_dout  out  NRD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
rd_busy  out  NRD  scoreboard busy flag for each read address
w_en  in  1  writeback enable
w_addr  in  ADDR_W  writeback address
w_din  in  DATA_W  writeback data
set_en  in  1  mark set_addr busy (producer issued)
set_addr  in  ADDR_W  register to mark busy
clr_req  in  1  start sweep-clear (single-cycle pulse or level)
clr_busy  out  1  high while a sweep-clear is in progress

Behaviour:
- Reset: rst_n=0 sampled at a clk edge.
  - All entries become 0, all busy bits 0, FSM goes to IDLE, sweep pointer 1, clr_busy 0.
  - Reads are combinational, so rd_dout = 0 and rd_busy = 0 for every address after the reset edge.
  - rst_n takes priority over every other input, including mid-sweep: the sweep is aborted.
- Entry 0 is hardwired:
  - Reads of address 0 always return 0 and rd_busy 0, including under bypass.
  - Writes to address 0 are dropped.
  - set_en with set_addr 0 is ignored.
- Read path: combinational, zero latency, NRD ports fully independent.
  - Port i returns stored data[rd_addr_i].
  - When BYPASS=1, FSM is IDLE, w_en=1, w_addr==rd_addr_i and the address is nonzero, port i returns w_din instead.
  - When BYPASS=0, the written value is visible only from the cycle after the write edge.
- rd_busy_i = busy[rd_addr_i], except that when BYPASS=1 and the same-cycle write to that address is in effect, it reads 0. A set_en in the same cycle does not affect rd_busy until the next edge.
- Write: w_en=1 in IDLE updates data[w_addr] at the edge.
- Scoreboard (IDLE only), per edge:
  - set_en sets busy[set_addr].
  - w_en clears busy[w_addr].
  - If set_addr == w_addr with both enabled: data is written and busy ends at 1 (the new producer wins).
  - Different addresses are handled independently.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on clr_req=1. The pointer starts at 1 and clr_busy rises the cycle after clr_req.
  - SWEEP: on each edge, data[ptr] <= 0, busy[ptr] <= 0, ptr increments.
  - At ptr == DEPTH-1 the entry is cleared and the FSM returns to IDLE with ptr reset to 1.
  - A sweep takes exactly DEPTH-1 cycles (31 by default). clr_busy is high for exactly those DEPTH-1 cycles.
- While in SWEEP:
  - w_en, set_en and clr_req are ignored; their writes are lost, with no queuing.
  - Bypass is disabled. Reads return current stored data, so partially cleared contents are visible.
- The pointer is ADDR_W bits wide. Reaching DEPTH-1 ends the sweep; it never wraps to 0.

Test Plan:
- Reset:
  - Write 0xDEADBEEF to r5, assert rst_n=0 for one edge.
  - Expected: rd_dout for r5 = 0 and rd_busy = 0 on all ports.
  - Write to r0 then read r0 -> 0.
- Bypass with BYPASS=1:
  - Same cycle: w_en=1, w_addr=7, w_din=0x12345678, rd_addr0=7 -> rd_dout0 = 0x12345678 before the edge; rd_addr1=8 is unaffected.
  - With BYPASS=0 -> old value before the edge, new value after.
- Scoreboard:
  - set_en on r3 -> rd_busy = 1 from the next cycle.
  - w_en on r3 -> busy clears and the same-cycle read shows rd_busy = 0.
  - Simultaneous set_en and w_en on r3 -> busy remains 1 and data is written.
- Multi-port:
  - NRD=3, addresses {1, 2, 31} loaded with distinct values -> all three ports return the correct values simultaneously.
  - Repeat with all three ports on the same address.
- Sweep:
  - Fill r1..r31 with nonzero values and set busy on r10, then pulse clr_req.
  - Expected: clr_busy high for exactly 31 cycles; all entries 0 and rd_busy 0 afterwards.
  - A w_en to r4 during the sweep is lost (r4 reads 0).
- Reset mid-sweep: rst_n=0 at sweep cycle 10 -> clr_busy = 0 after the edge, all entries 0, and a new clr_req restarts the sweep from pointer 1.
